// File: rtl/rvfi_retire_pkg.sv
// Shared types for the RVFI retirement packer: record payload, control states, widths.
// Data widths come from RISCV_FORMAL_NRET / RISCV_FORMAL_XLEN / RISCV_FORMAL_ILEN.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 2
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_ILEN
`define RISCV_FORMAL_ILEN 32
`endif

package rvfi_retire_pkg;

  localparam int unsigned NRET    = `RISCV_FORMAL_NRET;
  localparam int unsigned XLEN    = `RISCV_FORMAL_XLEN;
  localparam int unsigned ILEN    = `RISCV_FORMAL_ILEN;
  localparam int unsigned ORDER_W = 8;

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic            intr;
  } rec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/rvfi_retire_fifo.sv
// Record FIFO: one push and a pop of 0..NRET oldest entries per cycle; exposes the
// NRET oldest entries so the packer can fan them out to channels in one cycle.
module rvfi_retire_fifo
  import rvfi_retire_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  rec_t                 push_data,
  input  logic [CNT_W-1:0]     pop_n,
  output logic [CNT_W-1:0]     count,
  output rec_t [NRET-1:0]      peek
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    count_d  = count_q + CNT_W'(push) - pop_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int unsigned j = 0; j < NRET; j++) begin
      peek[j] = mem_q[rd_ptr_q + PTR_W'(j)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rvfi_retire_packer.sv
// Packs single retirement records into NRET-wide RVFI groups with running order numbers.
// Optional PC-chain checker enabled by defining RVFI_RETIRE_PACKER_PCCHAIN_EN.
module rvfi_retire_packer
  import rvfi_retire_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ILEN-1:0]           in_insn,
  input  logic [XLEN-1:0]           in_pc_rdata,
  input  logic [XLEN-1:0]           in_pc_wdata,
  input  logic                      in_trap,
  input  logic                      in_halt,
  input  logic                      in_intr,
  output logic [NRET-1:0]           rvfi_valid,
  output logic [NRET*ORDER_W-1:0]   rvfi_order,
  output logic [NRET*ILEN-1:0]      rvfi_insn,
  output logic [NRET-1:0]           rvfi_trap,
  output logic [NRET-1:0]           rvfi_halt,
  output logic [NRET-1:0]           rvfi_intr,
  output logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]      rvfi_pc_wdata
`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
  ,
  output logic                      pc_chain_err
`endif
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDLE_W = 8;

  state_e                  state_q, state_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [ORDER_W-1:0]      order_q, order_d;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        emit_n;
  logic                    push;
  rec_t                    push_rec;
  rec_t [NRET-1:0]         peek;

  logic [NRET-1:0]         valid_q, valid_d;
  logic [NRET*ORDER_W-1:0] order_o_q, order_o_d;
  logic [NRET*ILEN-1:0]    insn_q, insn_d;
  logic [NRET-1:0]         trap_q, trap_d;
  logic [NRET-1:0]         halt_q, halt_d;
  logic [NRET-1:0]         intr_q, intr_d;
  logic [NRET*XLEN-1:0]    pc_rdata_q, pc_rdata_d;
  logic [NRET*XLEN-1:0]    pc_wdata_q, pc_wdata_d;

  assign in_ready = (state_q == RUN) && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign push_rec = '{insn: in_insn, pc_rdata: in_pc_rdata, pc_wdata: in_pc_wdata,
                      trap: in_trap, halt: in_halt, intr: in_intr};

  rvfi_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop_n     (emit_n),
    .count     (count),
    .peek      (peek)
  );

  // Group size is decided on the occupancy before this cycle's push.
  always_comb begin
    emit_n = '0;
    if (state_q != HALTED) begin
      if (count >= CNT_W'(NRET)) begin
        emit_n = CNT_W'(NRET);
      end else if (count != '0 &&
                   (state_q == DRAIN || idle_q == IDLE_W'(TIMEOUT - 1))) begin
        emit_n = count;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    order_d = order_q + ORDER_W'(emit_n);
    if (push || emit_n != '0) begin
      idle_d = '0;
    end else if (count != '0 && count < CNT_W'(NRET) &&
                 idle_q != IDLE_W'(TIMEOUT - 1)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    case (state_q)
      RUN:     if (push && in_halt) state_d = DRAIN;
      DRAIN:   if (emit_n != '0 && emit_n == count) state_d = HALTED;
      default: ;
    endcase
  end

  // Unused channels stay fully zeroed so checkers never see stale fields.
  always_comb begin
    valid_d    = '0;
    order_o_d  = '0;
    insn_d     = '0;
    trap_d     = '0;
    halt_d     = '0;
    intr_d     = '0;
    pc_rdata_d = '0;
    pc_wdata_d = '0;
    for (int unsigned j = 0; j < NRET; j++) begin
      if (CNT_W'(j) < emit_n) begin
        valid_d[j]                        = 1'b1;
        order_o_d[j*ORDER_W +: ORDER_W]   = order_q + ORDER_W'(j);
        insn_d[j*ILEN +: ILEN]            = peek[j].insn;
        trap_d[j]                         = peek[j].trap;
        halt_d[j]                         = peek[j].halt;
        intr_d[j]                         = peek[j].intr;
        pc_rdata_d[j*XLEN +: XLEN]        = peek[j].pc_rdata;
        pc_wdata_d[j*XLEN +: XLEN]        = peek[j].pc_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      idle_q     <= '0;
      order_q    <= '0;
      valid_q    <= '0;
      order_o_q  <= '0;
      insn_q     <= '0;
      trap_q     <= '0;
      halt_q     <= '0;
      intr_q     <= '0;
      pc_rdata_q <= '0;
      pc_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      order_q    <= order_d;
      valid_q    <= valid_d;
      order_o_q  <= order_o_d;
      insn_q     <= insn_d;
      trap_q     <= trap_d;
      halt_q     <= halt_d;
      intr_q     <= intr_d;
      pc_rdata_q <= pc_rdata_d;
      pc_wdata_q <= pc_wdata_d;
    end
  end

  assign rvfi_valid    = valid_q;
  assign rvfi_order    = order_o_q;
  assign rvfi_insn     = insn_q;
  assign rvfi_trap     = trap_q;
  assign rvfi_halt     = halt_q;
  assign rvfi_intr     = intr_q;
  assign rvfi_pc_rdata = pc_rdata_q;
  assign rvfi_pc_wdata = pc_wdata_q;

`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
  logic            seen_q, seen_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  // Sticky flag: an accepted non-interrupt record must start where the previous one ended.
  always_comb begin
    seen_d    = seen_q;
    err_d     = err_q;
    last_pc_d = last_pc_q;
    if (push) begin
      if (seen_q && !in_intr && in_pc_rdata != last_pc_q) err_d = 1'b1;
      seen_d    = 1'b1;
      last_pc_d = in_pc_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      last_pc_q <= '0;
    end else begin
      seen_q    <= seen_d;
      err_q     <= err_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign pc_chain_err = err_q;
`endif

endmodule

// File: tb/tb_rvfi_retire_packer.sv
// Scoreboard bench for rvfi_retire_packer: stimulus predicts group sizes and records,
// a monitor compares every emitted cycle. Honours RVFI_RETIRE_PACKER_PCCHAIN_EN.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 2
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_ILEN
`define RISCV_FORMAL_ILEN 32
`endif

module tb_rvfi_retire_packer;

  localparam int NRET    = `RISCV_FORMAL_NRET;
  localparam int XLEN    = `RISCV_FORMAL_XLEN;
  localparam int ILEN    = `RISCV_FORMAL_ILEN;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic            intr;
    logic [7:0]      order;
  } trec_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [ILEN-1:0]        in_insn = '0;
  logic [XLEN-1:0]        in_pc_rdata = '0;
  logic [XLEN-1:0]        in_pc_wdata = '0;
  logic                   in_trap = 1'b0;
  logic                   in_halt = 1'b0;
  logic                   in_intr = 1'b0;
  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*8-1:0]      rvfi_order;
  logic [NRET*ILEN-1:0]   rvfi_insn;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET-1:0]        rvfi_halt;
  logic [NRET-1:0]        rvfi_intr;
  logic [NRET*XLEN-1:0]   rvfi_pc_rdata;
  logic [NRET*XLEN-1:0]   rvfi_pc_wdata;
`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
  logic                   pc_chain_err;
`endif

  always #5 clock = ~clock;

  rvfi_retire_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_insn       (in_insn),
    .in_pc_rdata   (in_pc_rdata),
    .in_pc_wdata   (in_pc_wdata),
    .in_trap       (in_trap),
    .in_halt       (in_halt),
    .in_intr       (in_intr),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_trap     (rvfi_trap),
    .rvfi_halt     (rvfi_halt),
    .rvfi_intr     (rvfi_intr),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata)
`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
    ,
    .pc_chain_err  (pc_chain_err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  trec_t exp_rec_q[$];
  int    exp_k_q[$];
  bit    exp_err_q[$];

  // Reference model state: records accepted but not yet emitted, timing and halt status.
  int              occ = 0;
  int              edge_i = 0;
  int              last_act = 0;
  bit              draining = 1'b0;
  int              acc_cnt = 0;
  bit              chain_seen = 1'b0;
  bit              chain_err = 1'b0;
  logic [XLEN-1:0] chain_pc = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic trec_t zero_rec();
    trec_t r;
    r.insn = '0; r.pc_rdata = '0; r.pc_wdata = '0;
    r.trap = 1'b0; r.halt = 1'b0; r.intr = 1'b0; r.order = '0;
    return r;
  endfunction

  function automatic trec_t mk(input logic [XLEN-1:0] rd, input logic [XLEN-1:0] wd,
                               input logic h, input logic i);
    trec_t r;
    r = zero_rec();
    r.insn = ILEN'({$urandom, $urandom});
    r.pc_rdata = rd;
    r.pc_wdata = wd;
    r.halt = h;
    r.intr = i;
    return r;
  endfunction

  // Mostly chained PCs with occasional jumps, traps and interrupts.
  function automatic trec_t rand_rec(input bit h);
    trec_t r;
    r = zero_rec();
    r.insn     = ILEN'({$urandom, $urandom});
    r.pc_rdata = ($urandom_range(0, 15) == 0) ? XLEN'({$urandom, $urandom}) : chain_pc;
    r.pc_wdata = ($urandom_range(0, 7) == 0) ? XLEN'({$urandom, $urandom})
                                              : r.pc_rdata + XLEN'(4);
    r.trap = ($urandom_range(0, 7) == 0);
    r.intr = ($urandom_range(0, 7) == 0);
    r.halt = h;
    return r;
  endfunction

  // One clock cycle of stimulus plus the prediction for the following edge.
  task automatic cycle(input bit v, input trec_t r, input bit rst);
    int k;
    bit push;
    @(negedge clock);
    reset       = rst;
    in_valid    = v;
    in_insn     = r.insn;
    in_pc_rdata = r.pc_rdata;
    in_pc_wdata = r.pc_wdata;
    in_trap     = r.trap;
    in_halt     = r.halt;
    in_intr     = r.intr;
    #1;
    if (rst) begin
      exp_rec_q.delete();
      occ = 0; last_act = edge_i; draining = 1'b0; acc_cnt = 0;
      chain_seen = 1'b0; chain_err = 1'b0; chain_pc = '0;
      exp_k_q.push_back(0);
      exp_err_q.push_back(1'b0);
    end else begin
      chk("in_ready", 256'(in_ready), 256'(!draining && occ < DEPTH));
      push = v && in_ready;
      if (draining && occ == 0) k = 0;
      else if (occ >= NRET) k = NRET;
      else if (occ > 0 && (draining || edge_i - last_act >= TIMEOUT)) k = occ;
      else k = 0;
      if (push) begin
        r.order = 8'(acc_cnt);
        acc_cnt++;
        exp_rec_q.push_back(r);
        if (chain_seen && !r.intr && r.pc_rdata != chain_pc) chain_err = 1'b1;
        chain_seen = 1'b1;
        chain_pc = r.pc_wdata;
        if (r.halt) draining = 1'b1;
      end
      occ = occ + int'(push) - k;
      if (push || k > 0) last_act = edge_i;
      exp_k_q.push_back(k);
      exp_err_q.push_back(chain_err);
    end
    edge_i++;
  endtask

  // Monitor: after every edge, compare each channel against the predicted group.
  initial begin
    int k;
    bit e;
    trec_t r;
    logic [255:0] obs, expv;
    forever begin
      @(posedge clock);
      #1;
      if (exp_k_q.size() != 0) begin
        k = exp_k_q.pop_front();
        e = exp_err_q.pop_front();
        for (int ch = 0; ch < NRET; ch++) begin
          obs = 256'({rvfi_valid[ch], rvfi_order[ch*8 +: 8], rvfi_insn[ch*ILEN +: ILEN],
                      rvfi_pc_rdata[ch*XLEN +: XLEN], rvfi_pc_wdata[ch*XLEN +: XLEN],
                      rvfi_trap[ch], rvfi_halt[ch], rvfi_intr[ch]});
          expv = '0;
          if (ch < k) begin
            if (exp_rec_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL scoreboard_empty: channel %0d expected a record, none queued", ch);
            end else begin
              r = exp_rec_q.pop_front();
              expv = 256'({1'b1, r.order, r.insn, r.pc_rdata, r.pc_wdata,
                            r.trap, r.halt, r.intr});
            end
          end
          chk($sformatf("channel%0d", ch), obs, expv);
        end
`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
        chk("pc_chain_err", 256'(pc_chain_err), 256'(e));
`else
        if (e) begin end
`endif
      end
    end
  end

  initial begin
    trec_t z;
    z = zero_rec();
    repeat (3) cycle(1'b0, z, 1'b1);

    // Full group: two chained records emit together one cycle later.
    cycle(1'b1, mk(32'h100, 32'h104, 1'b0, 1'b0), 1'b0);
    cycle(1'b1, mk(32'h104, 32'h108, 1'b0, 1'b0), 1'b0);
    repeat (3) cycle(1'b0, z, 1'b0);

    // Lone record flushed by the idle timeout as a one-channel group.
    cycle(1'b1, mk(32'h108, 32'h10c, 1'b0, 1'b0), 1'b0);
    repeat (TIMEOUT + 3) cycle(1'b0, z, 1'b0);

    // Continuous source: order counter wraps past 255.
    repeat (300) cycle(1'b1, rand_rec(1'b0), 1'b0);
    repeat (TIMEOUT + 2) cycle(1'b0, z, 1'b0);

    // Varying densities.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 120; i++) begin
        cycle($urandom_range(0, 3) <= p, rand_rec(1'b0), 1'b0);
      end
    end
    repeat (TIMEOUT + 2) cycle(1'b0, z, 1'b0);

    // Halt on the third record: groups {0,1} then {2}, then nothing accepted.
    cycle(1'b0, z, 1'b1);
    cycle(1'b1, rand_rec(1'b0), 1'b0);
    cycle(1'b1, rand_rec(1'b0), 1'b0);
    cycle(1'b1, rand_rec(1'b1), 1'b0);
    repeat (8) cycle(1'b1, rand_rec(1'b0), 1'b0);

    // Halt into an empty FIFO.
    cycle(1'b0, z, 1'b1);
    cycle(1'b1, rand_rec(1'b1), 1'b0);
    repeat (5) cycle(1'b1, rand_rec(1'b0), 1'b0);

    // Reset with a buffered record discards it.
    cycle(1'b0, z, 1'b1);
    repeat (3) cycle(1'b1, rand_rec(1'b0), 1'b0);
    cycle(1'b0, z, 1'b1);
    repeat (TIMEOUT + 3) cycle(1'b0, z, 1'b0);

`ifdef RVFI_RETIRE_PACKER_PCCHAIN_EN
    // Broken chain without interrupt sets the flag; with interrupt it stays clear.
    cycle(1'b0, z, 1'b1);
    cycle(1'b1, mk(32'h100, 32'h104, 1'b0, 1'b0), 1'b0);
    cycle(1'b1, mk(32'h104, 32'h108, 1'b0, 1'b0), 1'b0);
    cycle(1'b1, mk(32'h200, 32'h204, 1'b0, 1'b0), 1'b0);
    repeat (TIMEOUT + 3) cycle(1'b0, z, 1'b0);
    cycle(1'b0, z, 1'b1);
    cycle(1'b1, mk(32'h100, 32'h104, 1'b0, 1'b0), 1'b0);
    cycle(1'b1, mk(32'h104, 32'h108, 1'b0, 1'b0), 1'b0);
    cycle(1'b1, mk(32'h200, 32'h204, 1'b0, 1'b1), 1'b0);
    repeat (TIMEOUT + 3) cycle(1'b0, z, 1'b0);
`endif

    // Mixed traffic with occasional halts and resets.
    cycle(1'b0, z, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ((draining && occ == 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        cycle(1'b0, z, 1'b1);
      else
        cycle($urandom_range(0, 2) != 0, rand_rec($urandom_range(0, 39) == 0), 1'b0);
    end
    repeat (TIMEOUT + 4) cycle(1'b0, z, 1'b0);

    @(posedge clock);
    #2;
    chk("leftover_records", 256'(exp_rec_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_packer.md
Name: rvfi_retire_packer

Overview:
- Transmitter side of the RVFI retirement interface.
- Accepts single retirement records from a core-side or testbench source through a valid/ready handshake.
- Buffers the records and emits them as packed RVFI words on `RISCV_FORMAL_NRET channels, with monotonically numbered rvfi_order.
- Drives the RVFI inputs of the formal checkers (pc, order, causal checks) in multi-retire configurations.

Parameters:
- DEPTH, 8, FIFO depth in records; power of two, >= `RISCV_FORMAL_NRET.
- TIMEOUT, 4, idle cycles before a partial (fewer than NRET) group is flushed; 1..255.
- Data widths come from `RISCV_FORMAL_NRET, `RISCV_FORMAL_XLEN and `RISCV_FORMAL_ILEN.

Ports:
- clock  in  1  single clock, all logic posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  record offered.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_insn  in  ILEN  instruction word.
- in_pc_rdata  in  XLEN  PC of the instruction.
- in_pc_wdata  in  XLEN  next PC.
- in_trap  in  1  trap flag.
- in_halt  in  1  last record before halt.
- in_intr  in  1  first instruction of a trap handler.
- rvfi_valid  out  NRET  per-channel valid.
- rvfi_order  out  NRET*8  per-channel order.
- rvfi_insn  out  NRET*ILEN  per-channel instruction word.
- rvfi_trap / rvfi_halt / rvfi_intr  out  NRET each  per-channel flags.
- rvfi_pc_rdata / rvfi_pc_wdata  out  NRET*XLEN each  per-channel PCs.

Behaviour:
- Reset:
  - All rvfi_* outputs are 0.
  - FIFO is empty and the order counter is 0.
  - State is RUN, in_ready = 1 on the cycle after reset deasserts.
  - Reset mid-operation discards buffered records without emitting them.
- Input handshake:
  - in_ready = (state == RUN) && (count < DEPTH).
  - A push is accepted on the same edge as a pop.
  - in_ready is combinational from registered state only.
- Emission:
  - rvfi_* outputs are registered and asserted for exactly one cycle per group.
  - k records occupy channels 0..k-1; channels k..NRET-1 have valid = 0 and all fields 0.
  - Order of record j in a group = order_cnt + j, modulo 256.
  - order_cnt advances by k.
  - Channel index follows FIFO order: oldest record on channel 0.
- Emit conditions, evaluated on the registered count before the current push:
  - (a) count >= NRET: emit NRET records.
  - (b) 0 < count < NRET and idle_cnt == TIMEOUT-1: emit count records.
  - (c) state == DRAIN and count > 0: emit min(count, NRET) records.
- idle_cnt:
  - Increments while 0 < count < NRET and no push occurs.
  - Clears on any push or emit.
  - Saturates at TIMEOUT-1.
- Minimum latency is 1 cycle, from the accepting edge to rvfi_valid when count reaches NRET.
- State machine:
  - RUN -> DRAIN when a record with in_halt = 1 is accepted.
  - DRAIN -> HALTED on the emit that removes the last record.
  - HALTED is held until reset; outputs are 0 and in_ready = 0.
- Boundaries:
  - Full FIFO: in_ready = 0 and the offered record is held by the source.
  - Order wrap: 255 is followed by 0 with no gap.
  - A halt record accepted into an empty FIFO emits on the next cycle as a 1-channel group.

Optional Feature:
- Macro: RVFI_RETIRE_PACKER_PCCHAIN_EN.
- When defined:
  - Adds output pc_chain_err (1 bit, reset 0, sticky until reset).
  - The block tracks the pc_wdata of the last accepted record.
  - On an accepted record that is not the first since reset, with in_intr = 0 and in_pc_rdata != tracked value, pc_chain_err sets on the next edge.
- When undefined: the port and tracking logic are absent.

Decomposition:
- Package rvfi_retire_pkg:
  - record struct (insn, pc_rdata, pc_wdata, trap, halt, intr).
  - state enum {RUN, DRAIN, HALTED}.
  - ORDER_W = 8.
- Sub-module rvfi_retire_fifo:
  - Synchronous FIFO of records with count output.
  - Multi-pop of 0..NRET oldest entries per cycle.

Test Plan:
- NRET=2: push 2 records, PCs 0x100->0x104 and 0x104->0x108 -> next cycle rvfi_valid=2'b11, orders 0 and 1, channel 0 pc_rdata=0x100.
- NRET=2, TIMEOUT=4: push 1 record, then idle -> rvfi_valid=2'b01 on the 4th idle cycle; channel 1 fields all 0.
- DEPTH=8, source always valid, no emit possible (NRET > DEPTH setup disallowed, so use stalled-output model) -> in_ready drops at count 8 and no record is lost or duplicated; order values are continuous.
- Push 300 records -> after order 255 the next record has order 0; no gaps.
- 3rd record has in_halt=1 with NRET=2 -> groups {0,1} then {2}; afterwards in_ready=0 and rvfi_valid=0 until reset.
- PCCHAIN_EN: record 2 pc_rdata=0x200 after pc_wdata=0x108 -> pc_chain_err=1 next cycle and stays 1; with in_intr=1 instead -> stays 0.
